// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its helpers.
//   CPU_AWIDTH    default word-address / PC width
//   CPU_DWIDTH    default instruction width
//   CPU_RESET_PC  first fetch address after reset
//   fetch_entry_t one buffered fetch: {pc, instr}
package cpu_pkg;

  localparam int CPU_AWIDTH = 16;
  localparam int CPU_DWIDTH = 16;
  localparam logic [CPU_AWIDTH-1:0] CPU_RESET_PC = '0;

  typedef struct packed {
    logic [CPU_AWIDTH-1:0] pc;
    logic [CPU_DWIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries between the memory return path and decode.
// The head entry always sits in entries_q[0], so the output is straight from a register.
// Ports:
//   clk, rst    clock, synchronous active-high reset (empties FIFO, zeroes entries)
//   push        write push_data at the tail
//   push_data   entry to write
//   pop         remove the head entry
//   flush       discard all entries; wins over push and pop
//   head        current head entry (stale/zero when count == 0)
//   count       number of valid entries, 0..DEPTH
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  entries_q [DEPTH];
  fetch_entry_t  entries_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          pop_ok;
  logic          push_ok;
  logic [CW-1:0] wr_idx;

  // Guard against pops on empty and pushes on full; the caller's credit
  // scheme should never rely on either, but the FIFO stays consistent.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);
  // Tail slot after the (optional) shift caused by a pop.
  assign wr_idx  = count_q - CW'(pop_ok);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    fetch_entry_t shifted;
    if (gi < DEPTH - 1) begin : g_mid
      assign shifted = pop_ok ? entries_q[gi+1] : entries_q[gi];
    end else begin : g_last
      assign shifted = entries_q[gi];
    end
    // Flushing only clears count; entry contents are don't-care afterwards.
    assign entries_d[gi] = flush ? entries_q[gi]
                         : ((push_ok && (wr_idx == CW'(gi))) ? push_data : shifted);
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign head  = entries_q[0];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, drives a registered-read instruction memory
// (1-cycle latency, no enable) and hands {pc, instr} pairs to decode via valid/ready.
// A branch redirect flushes the output buffer and drops the in-flight response.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   mem_raddr      memory read address (combinational: branch target or pc)
//   mem_rdata      memory data, valid one cycle after mem_raddr
//   branch_valid   single-cycle redirect request
//   branch_target  redirect address
//   out_valid      out_instr/out_pc hold a valid fetch
//   out_ready      decode accepts the head entry
//   out_instr      fetched instruction
//   out_pc         address of out_instr
// The buffered entry layout comes from cpu_pkg::fetch_entry_t, so AWIDTH/DWIDTH
// must match the package widths.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              AWIDTH     = CPU_AWIDTH,
  parameter int              DWIDTH     = CPU_DWIDTH,
  parameter logic [AWIDTH-1:0] RESET_PC = CPU_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              branch_valid,
  input  logic [AWIDTH-1:0] branch_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_instr,
  output logic [AWIDTH-1:0] out_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [AWIDTH-1:0] pc_q;
  logic [AWIDTH-1:0] pc_d;
  logic              inflight_q;
  logic              inflight_d;
  logic [AWIDTH-1:0] inflight_pc_q;
  logic [AWIDTH-1:0] inflight_pc_d;

  logic [CW-1:0]     fifo_count;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  logic              pop;
  logic              fifo_pop;
  logic              push;
  logic [CW:0]       occupancy;
  logic              credit;
  logic              issue;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  // A redirect discards the head, so decode's accept that cycle does not count.
  assign fifo_pop  = pop && !branch_valid;

  // Slots already spoken for once this cycle's pop leaves: buffered entries
  // plus the word coming back from memory. pop implies fifo_count >= 1.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign credit    = occupancy < (CW+1)'(FIFO_DEPTH);
  // Branches always issue: the flush frees every slot this cycle.
  assign issue     = !rst && (branch_valid || credit);

  assign mem_raddr = branch_valid ? branch_target : pc_q;

  // The returning word belongs to a fetch that a redirect has just killed.
  assign push       = inflight_q && !branch_valid;
  assign push_entry = '{pc: inflight_pc_q, instr: mem_rdata};

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (issue) begin
      pc_d          = mem_raddr + AWIDTH'(1);
      inflight_d    = 1'b1;
      inflight_pc_d = mem_raddr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .flush    (branch_valid),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign out_pc    = fifo_head.pc;
  assign out_instr = fifo_head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_raddr;
  logic [15:0] mem_rdata = '0;
  logic        branch_valid = 1'b0;
  logic [15:0] branch_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic        s_valid;
  logic [15:0] s_pc;
  logic [15:0] s_instr;
  logic [15:0] s_raddr;

  always #5 clk = ~clk;

  // Instruction memory model: registered read, mem[i] = i ^ A5A5.
  always @(posedge clk) mem_rdata <= mem_raddr ^ 16'hA5A5;

  fetch_unit #(
    .AWIDTH(16), .DWIDTH(16), .RESET_PC(16'h0000), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  // One clock cycle: apply inputs after a falling edge, sample 1 ns later,
  // then let the rising edge happen and return at the next falling edge.
  task automatic cycle(input logic r, input logic bv, input logic [15:0] bt, input logic rdy);
    rst = r; branch_valid = bv; branch_target = bt; out_ready = rdy;
    #1;
    s_valid = out_valid; s_pc = out_pc; s_instr = out_instr; s_raddr = mem_raddr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b0 || s_pc !== 16'h0 || s_instr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b pc=%h instr=%h expected 0/0000/0000", s_valid, s_pc, s_instr);
    end
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      if (k == 0) begin
        n_checks++;
        if (s_raddr !== 16'h0000) begin
          n_fail++;
          $display("FAIL reset_first_addr: got %h expected 0000", s_raddr);
        end
      end
      n_checks++;
      if (s_valid !== (k >= 2)) begin
        n_fail++;
        $display("FAIL reset_latency cyc%0d: got valid=%b expected %b", k, s_valid, (k >= 2));
      end else if (k >= 2 && (s_pc !== 16'(k - 2) || s_instr !== (16'(k - 2) ^ 16'hA5A5))) begin
        n_fail++;
        $display("FAIL reset_stream cyc%0d: got pc=%h instr=%h expected pc=%h", k, s_pc, s_instr, 16'(k - 2));
      end
      $display("reset cyc%0d valid=%b pc=%h instr=%h", k, s_valid, s_pc, s_instr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      n_checks++;
      if (s_valid !== 1'b1 || s_pc !== 16'h3 || s_instr !== (16'h3 ^ 16'hA5A5) || s_raddr !== 16'h5) begin
        n_fail++;
        $display("FAIL stall_hold %0d: got valid=%b pc=%h instr=%h raddr=%h expected 1/0003/A5A6/0005",
                 k, s_valid, s_pc, s_instr, s_raddr);
      end
      $display("stall %0d valid=%b pc=%h raddr=%h", k, s_valid, s_pc, s_raddr);
    end
    for (int j = 0; j < 4; j++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      n_checks++;
      if (s_valid !== 1'b1 || s_pc !== 16'(3 + j) || s_instr !== (16'(3 + j) ^ 16'hA5A5)) begin
        n_fail++;
        $display("FAIL stall_release %0d: got valid=%b pc=%h expected pc=%h", j, s_valid, s_pc, 16'(3 + j));
      end
      $display("release %0d pc=%h", j, s_pc);
    end
  endtask

  task automatic test_branch_full();
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (dut.fifo_count !== 2'd2) begin
      n_fail++;
      $display("FAIL branch_fifo_full: got count=%0d expected 2", dut.fifo_count);
    end
    cycle(1'b0, 1'b1, 16'h0100, 1'b1);
    n_checks++;
    if (s_raddr !== 16'h0100) begin
      n_fail++;
      $display("FAIL branch_raddr: got %h expected 0100", s_raddr);
    end
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_bubble: got valid=%b expected 0", s_valid);
    end
    for (int j = 0; j < 2; j++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      n_checks++;
      if (s_valid !== 1'b1 || s_pc !== 16'(16'h0100 + j) || s_instr !== (16'(16'h0100 + j) ^ 16'hA5A5)) begin
        n_fail++;
        $display("FAIL branch_target %0d: got valid=%b pc=%h instr=%h expected pc=%h",
                 j, s_valid, s_pc, s_instr, 16'(16'h0100 + j));
      end
      $display("branch_full deliver pc=%h instr=%h", s_pc, s_instr);
    end
  endtask

  task automatic test_back_to_back();
    int  lat;
    logic found;
    logic [15:0] first_pc;
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, 16'h0010, 1'b1);
    cycle(1'b0, 1'b1, 16'h0020, 1'b1);
    found = 1'b0; lat = 0; first_pc = '0;
    for (int j = 0; j < 6 && !found; j++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      if (s_valid) begin
        found = 1'b1; lat = j; first_pc = s_pc;
      end
    end
    n_checks++;
    if (!found || first_pc !== 16'h0020 || lat != 1) begin
      n_fail++;
      $display("FAIL back_to_back: got found=%b pc=%h wait=%0d expected pc=0020 wait=1", found, first_pc, lat);
    end
    $display("back_to_back first pc=%h", first_pc);
  endtask

  task automatic test_wrap();
    logic [15:0] exp_q [4];
    int got;
    exp_q[0] = 16'hFFFE; exp_q[1] = 16'hFFFF; exp_q[2] = 16'h0000; exp_q[3] = 16'h0001;
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, 16'hFFFE, 1'b1);
    got = 0;
    for (int j = 0; j < 12 && got < 4; j++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      if (s_valid) begin
        n_checks++;
        if (s_pc !== exp_q[got] || s_instr !== (exp_q[got] ^ 16'hA5A5)) begin
          n_fail++;
          $display("FAIL wrap %0d: got pc=%h instr=%h expected pc=%h", got, s_pc, s_instr, exp_q[got]);
        end
        $display("wrap deliver pc=%h", s_pc);
        got++;
      end
    end
    n_checks++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d deliveries expected 4", got);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    n_checks++;
    if (s_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got valid=%b expected 1", s_valid);
    end
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b0 || s_raddr !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_post: got valid=%b raddr=%h expected 0/0000", s_valid, s_raddr);
    end
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b1 || s_pc !== 16'h0000 || s_instr !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got valid=%b pc=%h instr=%h expected 1/0000/A5A5", s_valid, s_pc, s_instr);
    end
    $display("reset_mid restart pc=%h", s_pc);
  endtask

  // Reference model: delivered stream is sequential from the last redirect
  // (or RESET_PC after reset); output is valid from two cycles after a branch
  // and three cycles after the last reset cycle, and never drops otherwise.
  task automatic test_random();
    logic [15:0] exp_pc;
    int          valid_from;
    logic        r, bv, rdy, exp_valid;
    logic [15:0] bt;
    int          occ;
    int          deliveries;
    do_reset();
    exp_pc = 16'h0000; valid_from = 2; deliveries = 0;
    for (int k = 0; k < 10000; k++) begin
      r   = ($urandom_range(0, 499) == 0);
      bv  = ($urandom_range(0, 19) == 0);
      bt  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3)) : 16'($urandom);
      rdy = ($urandom_range(0, 9) < 7);
      cycle(r, bv, bt, rdy);
      exp_valid = (k >= valid_from);
      n_checks++;
      if (s_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL rand_valid cyc%0d: got %b expected %b", k, s_valid, exp_valid);
      end else if (exp_valid && (s_pc !== exp_pc || s_instr !== (exp_pc ^ 16'hA5A5))) begin
        n_fail++;
        $display("FAIL rand_data cyc%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                 k, s_pc, s_instr, exp_pc, exp_pc ^ 16'hA5A5);
      end
      if (bv && !r) begin
        n_checks++;
        if (s_raddr !== bt) begin
          n_fail++;
          $display("FAIL rand_raddr cyc%0d: got %h expected %h", k, s_raddr, bt);
        end
      end
      occ = int'(dut.fifo_count) + int'(dut.inflight_q);
      n_checks++;
      if (occ > DEPTH) begin
        n_fail++;
        $display("FAIL rand_occupancy cyc%0d: got %0d expected <= %0d", k, occ, DEPTH);
      end
      if (r) begin
        exp_pc = 16'h0000; valid_from = k + 3;
      end else if (bv) begin
        exp_pc = bt; valid_from = k + 2;
      end else if (s_valid && rdy) begin
        exp_pc = exp_pc + 16'h1;
        deliveries++;
      end
      if (k % 1000 == 0) $display("random cyc%0d valid=%b pc=%h", k, s_valid, s_pc);
    end
    $display("random run deliveries=%0d", deliveries);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stall();
    test_branch_full();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
